prog_mem_ctrl: RTL

Owns the single-port program memory that holds allocation instruction words for the sample-rate-converter controller. It shares that memory between two users: the host loader, which writes a program while prog=1, and the controller fetch path, which reads instruction words while running. It also tracks the program length, gates the controller enable, and flags overflowing loads. It sits between the host interface, the program RAM macro, and the Controller's fetch/pc ports.

---
 rtl/prog_mem_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/prog_mem_ctrl.sv
// prog_mem_ctrl
// Owns the single-port program RAM for the sample-rate-converter controller.
// The host loader writes a program into it while prog=1. The controller fetch
// path reads instruction words from it while running. The block also tracks
// the program length, gates the controller enable and flags loads that
// overflow the memory.
//
// State table:
//   IDLE | no owner; waits for a load request, or enters RUN if a program exists
//   LOAD | host owns the RAM port; beats are written at wr_ptr
//   RUN  | controller owns the RAM port; fetches are served with one pending read
//   ERR  | last load overflowed; waits for prog=0
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   prog            host load-mode request (level)
//   host_valid/host_ready/host_word/host_last   host beat handshake
//   fetch, pc       controller fetch pulse and program counter
//   instr_word      last fetched instruction, held between fetches
//   instr_valid     one-cycle pulse when instr_word is updated
//   mem_we/mem_addr/mem_wdata/mem_rdata   program RAM port (1-cycle read latency)
//   ctrl_en         controller enable, high only in RUN
//   prog_len        number of valid program words (0 = none)
//   load_err        sticky overflow flag for the last load
module prog_mem_ctrl #(
    parameter int INSTR_W      = 40,
    parameter int INSTR_ADDR_W = 4,
    parameter int PROG_SIZE    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    prog,
    input  logic                    host_valid,
    output logic                    host_ready,
    input  logic [INSTR_W-1:0]      host_word,
    input  logic                    host_last,
    input  logic                    fetch,
    input  logic [INSTR_ADDR_W-1:0] pc,
    output logic [INSTR_W-1:0]      instr_word,
    output logic                    instr_valid,
    output logic                    mem_we,
    output logic [INSTR_ADDR_W-1:0] mem_addr,
    output logic [INSTR_W-1:0]      mem_wdata,
    input  logic [INSTR_W-1:0]      mem_rdata,
    output logic                    ctrl_en,
    output logic [INSTR_ADDR_W:0]   prog_len,
    output logic                    load_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [INSTR_ADDR_W-1:0] LAST_ADDR = INSTR_ADDR_W'(PROG_SIZE - 1);
    localparam logic [INSTR_ADDR_W-1:0] ADDR_ONE  = INSTR_ADDR_W'(1);
    localparam logic [INSTR_ADDR_W:0]   LEN_ONE   = (INSTR_ADDR_W + 1)'(1);

    state_t                  state;
    state_t                  next_state;
    logic [INSTR_ADDR_W-1:0] wr_ptr;
    logic                    rd_pend;
    logic                    accept;
    logic                    fetch_go;
    logic                    capture;
    logic                    enter_load;
    logic                    pc_in_range;
    logic [INSTR_ADDR_W:0]   len_next;

    assign accept      = host_valid && host_ready;
    // A fetch arriving together with prog=1 is dropped: the host is taking the port.
    assign fetch_go    = (state == RUN) && fetch && !prog;
    // A pending read lands only if RUN is not being preempted in this cycle.
    assign capture     = rd_pend && (state == RUN) && !prog;
    assign enter_load  = (next_state == LOAD) && (state != LOAD);
    assign pc_in_range = ({1'b0, pc} < prog_len);
    assign len_next    = {1'b0, wr_ptr} + LEN_ONE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        host_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (prog) begin
                    next_state = LOAD;
                end else if (prog_len != '0) begin
                    next_state = RUN;
                end
            end
            LOAD: begin
                host_ready = prog;
                if (!prog) begin
                    next_state = IDLE;
                end else if (host_valid) begin
                    mem_we    = 1'b1;
                    mem_addr  = wr_ptr;
                    mem_wdata = host_word;
                    if (host_last) begin
                        next_state = IDLE;
                    end else if (wr_ptr == LAST_ADDR) begin
                        next_state = ERR;
                    end
                end
            end
            RUN: begin
                if (prog) begin
                    next_state = LOAD;
                end else if (fetch_go) begin
                    // Out-of-range pc wraps to the first program word.
                    mem_addr = pc_in_range ? pc : '0;
                end
            end
            ERR: begin
                if (!prog) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr      <= '0;
            prog_len    <= '0;
            load_err    <= 1'b0;
            ctrl_en     <= 1'b0;
            rd_pend     <= 1'b0;
            instr_valid <= 1'b0;
            instr_word  <= '0;
        end else begin
            if (enter_load) begin
                wr_ptr   <= '0;
                load_err <= 1'b0;
            end else if (accept) begin
                wr_ptr <= wr_ptr + ADDR_ONE;
            end

            if (state == LOAD) begin
                if (!prog) begin
                    prog_len <= '0;
                end else if (accept && host_last) begin
                    prog_len <= len_next;
                end else if (accept && (wr_ptr == LAST_ADDR)) begin
                    prog_len <= '0;
                    load_err <= 1'b1;
                end
            end

            // Registered from next_state so ctrl_en tracks state==RUN exactly.
            ctrl_en     <= (next_state == RUN);
            rd_pend     <= fetch_go;
            instr_valid <= capture;
            if (capture) begin
                instr_word <= mem_rdata;
            end
        end
    end

endmodule
